fetch_queue: RTL and testbench

- Instruction prefetch buffer directly downstream of the instruction-fetch stage.
- Captures {pc, instruction} pairs from fetch into a small FIFO and presents them in order to decode.
- in_ready drives the fetch stage's PC load_en, so backpressure stalls the PC.
- flush discards all buffered instructions on a taken branch or jump redirect.

---
 rtl/fetch_queue.sv | 101 ++++++++++
 tb/tb_fetch_queue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and decode; in_ready stalls the PC.
// Optional same-cycle empty-queue bypass enabled by FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_instruction,
    output logic              in_ready,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_instruction,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [XLEN-1:0]   pc_mem_q  [DEPTH];
    logic [XLEN-1:0]   ins_mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              not_empty;
    logic              bypass;
    logic              enq;
    logic              deq;
    logic              wr_en;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != FULL_CNT);
    assign count     = count_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = ~not_empty & in_valid & ~flush & ~reset;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed pair that decode takes immediately never touches storage.
    assign enq   = in_valid & in_ready & ~(bypass & out_ready);
    assign deq   = not_empty & out_ready;
    assign wr_en = enq & ~flush & ~reset;

    always_comb begin
        out_valid       = not_empty | bypass;
        out_pc          = '0;
        out_instruction = '0;
        if (not_empty) begin
            out_pc          = pc_mem_q[rd_ptr_q];
            out_instruction = ins_mem_q[rd_ptr_q];
        end else if (bypass) begin
            out_pc          = in_pc;
            out_instruction = in_instruction;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem_q[wr_ptr_q]  <= in_pc;
            ins_mem_q[wr_ptr_q] <= in_instruction;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default or bypass build).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instruction;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_ready;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(4), .ADDR_W(2), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_instruction(in_instruction),
        .in_ready(in_ready), .out_valid(out_valid), .out_pc(out_pc),
        .out_instruction(out_instruction), .out_ready(out_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    task automatic push(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc = pc;
        in_instruction = ins_of(pc);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                $display("FAIL reset_out_valid cyc %0d got %b exp 0", i, out_valid);
                errors++;
            end
            checks++;
            if (in_ready !== 1'b1) begin
                $display("FAIL reset_in_ready cyc %0d got %b exp 1", i, in_ready);
                errors++;
            end
            checks++;
            if (count !== 3'd0) begin
                $display("FAIL reset_count cyc %0d got %0d exp 0", i, count);
                errors++;
            end
            checks++;
            if (out_pc !== 32'h0 || out_instruction !== 32'h0) begin
                $display("FAIL reset_out_data cyc %0d got %h/%h exp 0/0", i, out_pc, out_instruction);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'(i * 4));
        #1;
        checks++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            $display("FAIL fill_full got count %0d rdy %b exp 4 0", count, in_ready);
            errors++;
        end
        push(32'h10);
        #1;
        checks++;
        if (count !== 3'd4) begin
            $display("FAIL fill_overflow_count got %0d exp 4", count);
            errors++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instruction !== ins_of(32'(i * 4))) begin
                $display("FAIL drain_order %0d got v%b %h/%h exp pc %h", i, out_valid, out_pc, out_instruction, 32'(i * 4));
                errors++;
            end
            tick();
        end
        out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            $display("FAIL drain_empty got count %0d v %b exp 0 0", count, out_valid);
            errors++;
        end
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            pc = 32'h100 + 32'(k * 4);
            in_pc = pc;
            in_instruction = ins_of(pc);
            #1;
`ifdef FETCH_QUEUE_BYPASS_EN
            checks++;
            if (count !== 3'd0 || out_valid !== 1'b1 || out_pc !== pc) begin
                $display("FAIL stream_bypass %0d got c%0d v%b pc %h exp c0 v1 pc %h", k, count, out_valid, out_pc, pc);
                errors++;
            end
`else
            if (k > 0) begin
                checks++;
                if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== pc - 32'h4
                    || out_instruction !== ins_of(pc - 32'h4)) begin
                    $display("FAIL stream %0d got c%0d v%b pc %h exp c1 v1 pc %h", k, count, out_valid, out_pc, pc - 32'h4);
                    errors++;
                end
            end
`endif
            tick();
        end
        in_valid = 1'b0;
`ifndef FETCH_QUEUE_BYPASS_EN
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h14C) begin
            $display("FAIL stream_tail got v%b pc %h exp v1 pc 0000014c", out_valid, out_pc);
            errors++;
        end
        tick();
`endif
        out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0) begin
            $display("FAIL stream_end_count got %0d exp 0", count);
            errors++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        push(32'h20);
        push(32'h24);
        push(32'h28);
        flush = 1'b1;
        out_ready = 1'b1;
        push(32'h2C);
        flush = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("FAIL flush_state got c%0d v%b r%b exp c0 v0 r1", count, out_valid, in_ready);
            errors++;
        end
        push(32'h80);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h80 || count !== 3'd1) begin
            $display("FAIL flush_next got v%b pc %h c%0d exp v1 pc 00000080 c1", out_valid, out_pc, count);
            errors++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0) begin
            $display("FAIL flush_drain got %0d exp 0", count);
            errors++;
        end
    endtask

    task automatic test_full_deq();
        logic [31:0] exp_pc [4];
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h180 + 32'(i * 4));
        in_valid = 1'b1;
        in_pc = 32'h200;
        in_instruction = ins_of(32'h200);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_pc !== 32'h180) begin
            $display("FAIL full_deq_rdy got r%b pc %h exp r0 pc 00000180", in_ready, out_pc);
            errors++;
        end
        tick();
        checks++;
        if (count !== 3'd3 || in_ready !== 1'b1) begin
            $display("FAIL full_deq_count got c%0d r%b exp c3 r1", count, in_ready);
            errors++;
        end
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd4) begin
            $display("FAIL full_refill got %0d exp 4", count);
            errors++;
        end
        exp_pc = '{32'h184, 32'h188, 32'h18C, 32'h200};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_pc !== exp_pc[i] || out_instruction !== ins_of(exp_pc[i])) begin
                $display("FAIL full_order %0d got %h exp %h", i, out_pc, exp_pc[i]);
                errors++;
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        push(32'h300);
        push(32'h304);
        reset = 1'b1;
        out_ready = 1'b1;
        push(32'h308);
        reset = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b1) begin
            $display("FAIL mid_reset got c%0d v%b pc %h r%b exp c0 v0 pc 0 r1", count, out_valid, out_pc, in_ready);
            errors++;
        end
    endtask

    task automatic test_bypass();
        in_valid = 1'b1;
        in_pc = 32'h40;
        in_instruction = 32'h0050_0093;
        out_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instruction !== 32'h0050_0093) begin
            $display("FAIL bypass_same got v%b %h/%h exp v1 00000040/00500093", out_valid, out_pc, out_instruction);
            errors++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            $display("FAIL bypass_after got c%0d v%b exp c0 v0", count, out_valid);
            errors++;
        end
`else
        checks++;
        if (out_valid !== 1'b0) begin
            $display("FAIL nobypass_same got v%b exp 0", out_valid);
            errors++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instruction !== 32'h0050_0093) begin
            $display("FAIL nobypass_next got v%b %h/%h exp v1 00000040/00500093", out_valid, out_pc, out_instruction);
            errors++;
        end
        tick();
        #1;
        checks++;
        if (count !== 3'd0) begin
            $display("FAIL nobypass_drain got %0d exp 0", count);
            errors++;
        end
`endif
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_pc = '0;
        in_instruction = '0;
        out_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_stream();
        test_flush();
        test_full_deq();
        test_mid_reset();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
